// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing defaults and write-arbiter state type
package fifo_pkg;

  localparam int FIFO_DATA_W = 64;
  localparam int FIFO_DEPTH  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector starting after last_i
module rr_pick
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // N <= 2**IW, so last_i + off (at most 2N-1) always fits in IW+1 bits
  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW:0] sum;

  // Walk offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    for (int off = N; off >= 1; off--) begin
      sum = {1'b0, last_i} + (IW+1)'(off);
      if (sum >= N_W) begin
        sum = sum - N_W;
      end
      if (req_i[sum[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-capped arbiter for the FIFO write port
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = FIFO_DATA_W,
  parameter  int MAX_BURST = FIFO_DEPTH,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic                      clock_i,
  input  logic                      rst_n_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_v_i,
  output logic [NUM_REQ-1:0]        req_bkp_o,
  output logic [DATA_W-1:0]         fifo_data_o,
  output logic                      fifo_v_o,
  input  logic                      fifo_bkp_i,
  output logic                      grant_v_o,
  output logic [IW-1:0]             grant_id_o
);

  arb_state_t          state_q;
  logic [IW-1:0]       last_q;
  logic                grant_v_q;
  logic [IW-1:0]       grant_id_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                fifo_v_q;
  logic [DATA_W-1:0]   fifo_data_q;
  logic [DATA_W-1:0]   fifo_data_d;

  logic                load_ok;
  logic                fifo_accept;
  logic [NUM_REQ-1:0]  gnt_oh;
  logic                beat_acc;
  logic                gnt_req_v;
  logic                burst_done;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_v_i),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Output register can take a beat when empty or when the FIFO drains it this cycle
  assign load_ok     = ~fifo_v_q | ~fifo_bkp_i;
  assign fifo_accept = fifo_v_q & ~fifo_bkp_i;
  assign gnt_oh      = grant_v_q ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_q) : '0;
  assign req_bkp_o   = ~(gnt_oh & {NUM_REQ{load_ok}});
  assign beat_acc    = |(req_v_i & ~req_bkp_o);
  assign gnt_req_v   = req_v_i[grant_id_q];
  assign cnt_d       = cnt_q + CW'(1);
  assign burst_done  = (cnt_d == CW'(MAX_BURST));

  // Route the granted requester's beat toward the output register
  always_comb begin
    fifo_data_d = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id_q == IW'(k)) begin
        fifo_data_d = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // Grant FSM: arbitrate in IDLE, count accepted beats in HOLD, release on drop or cap
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      last_q     <= IW'(NUM_REQ - 1);
      grant_v_q  <= 1'b0;
      grant_id_q <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_id_q <= pick_idx;
            grant_v_q  <= 1'b1;
            cnt_q      <= '0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (!gnt_req_v || (beat_acc && burst_done)) begin
            last_q    <= grant_id_q;
            grant_v_q <= 1'b0;
            state_q   <= IDLE;
          end else if (beat_acc) begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          grant_v_q <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: load on an accepted beat, empty when drained, hold under backpressure
  always_ff @(posedge clock_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_v_q    <= 1'b0;
      fifo_data_q <= '0;
    end else if (beat_acc) begin
      fifo_v_q    <= 1'b1;
      fifo_data_q <= fifo_data_d;
    end else if (fifo_accept) begin
      fifo_v_q <= 1'b0;
    end
  end

  assign fifo_v_o    = fifo_v_q;
  assign fifo_data_o = fifo_data_q;
  assign grant_v_o   = grant_v_q;
  assign grant_id_o  = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_v;
  logic [N-1:0]     req_bkp;
  logic [W-1:0]     fifo_data;
  logic             fifo_v;
  logic             fifo_bkp;
  logic             grant_v;
  logic [1:0]       grant_id;

  logic             rst3_n;
  logic [3*W-1:0]   req_data3;
  logic [2:0]       req_v3;
  logic [2:0]       req_bkp3;
  logic [W-1:0]     fifo_data3;
  logic             fifo_v3;
  logic             fifo_bkp3;
  logic             grant_v3;
  logic [1:0]       grant_id3;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) u_dut (
    .clock_i     (clk),
    .rst_n_i     (rst_n),
    .req_data_i  (req_data),
    .req_v_i     (req_v),
    .req_bkp_o   (req_bkp),
    .fifo_data_o (fifo_data),
    .fifo_v_o    (fifo_v),
    .fifo_bkp_i  (fifo_bkp),
    .grant_v_o   (grant_v),
    .grant_id_o  (grant_id)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_W(W), .MAX_BURST(2)) u_dut3 (
    .clock_i     (clk),
    .rst_n_i     (rst3_n),
    .req_data_i  (req_data3),
    .req_v_i     (req_v3),
    .req_bkp_o   (req_bkp3),
    .fifo_data_o (fifo_data3),
    .fifo_v_o    (fifo_v3),
    .fifo_bkp_i  (fifo_bkp3),
    .grant_v_o   (grant_v3),
    .grant_id_o  (grant_id3)
  );

  int total = 0;
  int bad   = 0;

  // reference model: holder = -1 means no grant outstanding
  int          m_holder, m_last, m_cnt;
  bit          m_ov;
  logic [63:0] m_od;
  int          n_holder, n_last, n_cnt;
  bit          n_ov;
  logic [63:0] n_od;
  logic [N-1:0] exp_bkp;

  int   q4[$];
  int   q3[$];
  logic pg4 = 1'b0;
  logic pg3 = 1'b0;

  // log every new grant of both instances
  always @(negedge clk) begin
    if (grant_v && !pg4) q4.push_back(int'(grant_id));
    if (grant_v3 && !pg3) q3.push_back(int'(grant_id3));
    pg4 <= grant_v;
    pg3 <= grant_v3;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_cnt    = 0;
    m_ov     = 1'b0;
    m_od     = '0;
  endtask

  task automatic model_eval();
    bit lok, acc;
    lok = !m_ov || !fifo_bkp;
    exp_bkp = '1;
    if (m_holder >= 0 && lok) exp_bkp[m_holder] = 1'b0;
    acc = (m_holder >= 0) && req_v[m_holder] && lok;
    n_holder = m_holder; n_last = m_last; n_cnt = m_cnt; n_ov = m_ov; n_od = m_od;
    if (acc) begin
      n_ov = 1'b1;
      n_od = req_data[m_holder*W +: W];
    end else if (m_ov && !fifo_bkp) begin
      n_ov = 1'b0;
    end
    if (m_holder < 0) begin
      for (int off = 1; off <= N; off++) begin
        int c = (m_last + off) % N;
        if (n_holder < 0 && req_v[c]) begin
          n_holder = c;
          n_cnt    = 0;
        end
      end
    end else if (!req_v[m_holder]) begin
      n_last   = m_holder;
      n_holder = -1;
    end else if (acc) begin
      n_cnt = m_cnt + 1;
      if (n_cnt == MB) begin
        n_last   = m_holder;
        n_holder = -1;
        n_cnt    = 0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic b);
    @(negedge clk);
    req_v    = v;
    fifo_bkp = b;
    for (int k = 0; k < N; k++) req_data[k*W +: W] = {$urandom, $urandom};
    #1;
    model_eval();
    chk("req_bkp", 64'(req_bkp), 64'(exp_bkp));
    @(posedge clk);
    #1;
    m_holder = n_holder; m_last = n_last; m_cnt = n_cnt; m_ov = n_ov; m_od = n_od;
    chk("fifo_v", 64'(fifo_v), 64'(m_ov));
    chk("fifo_data", fifo_data, m_od);
    chk("grant_v", 64'(grant_v), 64'(m_holder >= 0));
    if (m_holder >= 0) chk("grant_id", 64'(grant_id), 64'(m_holder));
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_v    = '0;
    fifo_bkp = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_fifo_v", 64'(fifo_v), 64'd0);
    chk("rst_grant_v", 64'(grant_v), 64'd0);
    chk("rst_req_bkp", 64'(req_bkp), 64'hF);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          base;
  int          exp_b[5] = '{0, 1, 2, 3, 0};
  int          exp_g[4] = '{0, 1, 2, 0};
  logic [63:0] held;

  initial begin
    rst_n     = 1'b0;
    rst3_n    = 1'b0;
    req_v     = '0;
    fifo_bkp  = 1'b0;
    req_data  = '0;
    req_v3    = 3'b111;
    req_data3 = {3{64'h0123_4567_89AB_CDEF}};
    fifo_bkp3 = 1'b0;
    model_reset();

    // reset values
    repeat (2) @(negedge clk);
    chk("reset_fifo_v", 64'(fifo_v), 64'd0);
    chk("reset_fifo_data", fifo_data, 64'd0);
    chk("reset_grant_v", 64'(grant_v), 64'd0);
    chk("reset_grant_id", 64'(grant_id), 64'd0);
    chk("reset_req_bkp", 64'(req_bkp), 64'hF);
    chk("reset3_req_bkp", 64'(req_bkp3), 64'h7);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    // requester 2 alone, three beats
    step(4'b0100, 1'b0);
    chk("a_grant_id", 64'(grant_id), 64'd2);
    chk("a_grant_v", 64'(grant_v), 64'd1);
    repeat (3) step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("a_release", 64'(grant_v), 64'd0);
    step(4'b0000, 1'b0);

    // all requesters valid from reset: order 0,1,2,3,0
    do_reset();
    base = q4.size();
    repeat (50) step(4'hF, 1'b0);
    chk("b_ngrants", 64'(q4.size() >= base + 5), 64'd1);
    for (int i = 0; i < 5; i++)
      if (base + i < q4.size()) chk("b_order", 64'(q4[base+i]), 64'(exp_b[i]));

    // backpressure stall mid-burst on requester 1
    repeat (2) step(4'b0000, 1'b0);
    repeat (3) step(4'b0010, 1'b0);
    held = fifo_data;
    repeat (5) step(4'b0010, 1'b1);
    chk("c_stable", fifo_data, held);
    chk("c_bkp1", 64'(req_bkp[1]), 64'd1);
    repeat (8) step(4'b0010, 1'b0);
    repeat (2) step(4'b0000, 1'b0);

    // wrap-around: last grant 3, then 0 and 3 compete
    repeat (3) step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    base = q4.size();
    repeat (20) step(4'b1001, 1'b0);
    chk("d_ngrants", 64'(q4.size() >= base + 2), 64'd1);
    if (base + 1 < q4.size()) begin
      chk("d_first", 64'(q4[base]), 64'd0);
      chk("d_second", 64'(q4[base+1]), 64'd3);
    end

    // asynchronous reset in the middle of a burst
    repeat (2) step(4'b0000, 1'b0);
    repeat (4) step(4'b0010, 1'b0);
    chk("e_pre_v", 64'(fifo_v), 64'd1);
    #3;
    rst_n = 1'b0;
    req_v = '0;
    #1;
    chk("e_async_v", 64'(fifo_v), 64'd0);
    chk("e_async_bkp", 64'(req_bkp), 64'hF);
    chk("e_async_gv", 64'(grant_v), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base = q4.size();
    repeat (4) step(4'hF, 1'b0);
    chk("e_ngrants", 64'(q4.size() > base), 64'd1);
    if (base < q4.size()) chk("e_restart", 64'(q4[base]), 64'd0);

    // randomized traffic and backpressure
    repeat (400) begin
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) v[k] = ($urandom_range(3, 0) != 0);
      step(v, $urandom_range(2, 0) == 0);
    end

    // three-requester instance: 0,1,2,0 and never index 3
    chk("g_ngrants", 64'(q3.size() >= 4), 64'd1);
    for (int i = 0; i < 4; i++)
      if (i < q3.size()) chk("g_order", 64'(q3[i]), 64'(exp_g[i]));
    foreach (q3[i]) chk("g_range", 64'(q3[i] < 3), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
